btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_debounce.sv | 139 +++++++++++++
 tb/tb_btn_debounce.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Multi-channel push-button conditioner: 2-flop synchronizer, debounce counter,
// press/release edge pulses and a per-channel auto-repeat FSM feeding btn_evt.
module btn_debounce #(
    parameter int N_BTN        = 2,
    parameter int DEBOUNCE     = 250000,
    parameter int REPEAT_DELAY = 12500000,
    parameter int REPEAT_RATE  = 2500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_i,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_evt
);

    localparam int DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RPT
    } state_t;

    logic                 r_run;
    logic [N_BTN-1:0]     r_sync1;
    logic [N_BTN-1:0]     r_sync2;
    logic [DB_W-1:0]      r_db_cnt      [N_BTN];
    logic [RPT_W-1:0]     r_rpt_cnt     [N_BTN];
    state_t               r_state       [N_BTN];

    logic [DB_W-1:0]      w_db_cnt_nxt  [N_BTN];
    logic [RPT_W-1:0]     w_rpt_cnt_nxt [N_BTN];
    state_t               w_state_nxt   [N_BTN];
    logic [N_BTN-1:0]     w_level_nxt;
    logic [N_BTN-1:0]     w_rise;
    logic [N_BTN-1:0]     w_fall;
    logic [N_BTN-1:0]     w_rpt;

    // Reset release is retimed by one flop so all state starts updating together
    // on the second edge after rst_n rises, never on the edge it deasserts near.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_run <= 1'b0;
        else        r_run <= 1'b1;
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
        w_level_nxt = btn_level;
        for (int i = 0; i < N_BTN; i++) begin
            w_db_cnt_nxt[i] = '0;
            if (r_sync2[i] != btn_level[i]) begin
                if (r_db_cnt[i] == DB_W'(DEBOUNCE - 1)) w_level_nxt[i] = r_sync2[i];
                else                                    w_db_cnt_nxt[i] = r_db_cnt[i] + 1'b1;
            end
        end
        w_rise = w_level_nxt & ~btn_level;
        w_fall = ~w_level_nxt & btn_level;
    end

    always_comb begin
        w_rpt = '0;
        for (int i = 0; i < N_BTN; i++) begin
            w_state_nxt[i]   = r_state[i];
            w_rpt_cnt_nxt[i] = r_rpt_cnt[i];
            case (r_state[i])
                ST_IDLE: begin
                    if (w_rise[i]) begin
                        w_state_nxt[i]   = ST_WAIT;
                        w_rpt_cnt_nxt[i] = '0;
                    end
                end
                ST_WAIT: begin
                    // Release wins over a terminal count landing on the same edge.
                    if (w_fall[i]) begin
                        w_state_nxt[i]   = ST_IDLE;
                        w_rpt_cnt_nxt[i] = '0;
                    end else if (r_rpt_cnt[i] == RPT_W'(REPEAT_DELAY - 1)) begin
                        w_rpt[i]         = 1'b1;
                        w_state_nxt[i]   = ST_RPT;
                        w_rpt_cnt_nxt[i] = '0;
                    end else begin
                        w_rpt_cnt_nxt[i] = r_rpt_cnt[i] + 1'b1;
                    end
                end
                ST_RPT: begin
                    if (w_fall[i]) begin
                        w_state_nxt[i]   = ST_IDLE;
                        w_rpt_cnt_nxt[i] = '0;
                    end else if (r_rpt_cnt[i] == RPT_W'(REPEAT_RATE - 1)) begin
                        w_rpt[i]         = 1'b1;
                        w_rpt_cnt_nxt[i] = '0;
                    end else begin
                        w_rpt_cnt_nxt[i] = r_rpt_cnt[i] + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt[i]   = ST_IDLE;
                    w_rpt_cnt_nxt[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            btn_evt     <= '0;
            // NOTE: the per-channel counter/state arrays are small registers, so they are
            // reset like any other flop rather than treated as an unreset memory.
            for (int i = 0; i < N_BTN; i++) begin
                r_db_cnt[i]  <= '0;
                r_rpt_cnt[i] <= '0;
                r_state[i]   <= ST_IDLE;
            end
        end else if (r_run) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            r_sync1     <= btn_i;
            r_sync2     <= r_sync1;
            btn_level   <= w_level_nxt;
            btn_press   <= w_rise;
            btn_release <= w_fall;
            btn_evt     <= w_rise | w_rpt;
            for (int i = 0; i < N_BTN; i++) begin
                r_db_cnt[i]  <= w_db_cnt_nxt[i];
                r_rpt_cnt[i] <= w_rpt_cnt_nxt[i];
                r_state[i]   <= w_state_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE=8, REPEAT_DELAY=32, REPEAT_RATE=16.
// Outputs are sampled 1 time unit after each rising edge; k counts edges since the stimulus change.
module tb_btn_debounce;

    logic       clk;
    logic       rst_n;
    logic [1:0] btn_i;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;
    logic [1:0] btn_evt;

    int tests_run;
    int tests_failed;

    btn_debounce #(
        .N_BTN(2),
        .DEBOUNCE(8),
        .REPEAT_DELAY(32),
        .REPEAT_RATE(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_i(btn_i),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .btn_evt(btn_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observed outputs packed as {level, press, release, evt}.
    function automatic logic [7:0] outs();
        return {btn_level, btn_press, btn_release, btn_evt};
    endfunction

    task automatic test_reset();
        logic [7:0] got;
        rst_n = 1'b0;
        btn_i = 2'b00;
        step();
        step();
        got = outs();
        tests_run++;
        if (got !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_hold got=%b exp=%b", got, 8'h00);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            got = outs();
            tests_run++;
            if (got !== 8'h00) begin
                tests_failed++;
                $display("FAIL reset_idle k=%0d got=%b exp=%b", k, got, 8'h00);
            end
        end
    endtask

    task automatic test_press();
        logic [7:0] got, exp;
        btn_i[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            got = outs();
            exp = {1'b0, k >= 10, 1'b0, k == 10, 2'b00, 1'b0, k == 10};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL press k=%0d got=%b exp=%b", k, got, exp);
            end
        end
        btn_i[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            got = outs();
            exp = {1'b0, k < 10, 2'b00, 1'b0, k == 10, 2'b00};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL release k=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] got;
        for (int k = 0; k < 70; k++) begin
            btn_i[0] = (k < 60) && ((k % 6) < 3);
            step();
            got = outs();
            tests_run++;
            if (got !== 8'h00) begin
                tests_failed++;
                $display("FAIL glitch k=%0d got=%b exp=%b", k, got, 8'h00);
            end
        end
        btn_i[0] = 1'b0;
    endtask

    task automatic test_repeat_hold();
        logic [7:0] got, exp;
        logic       lvl, evt;
        btn_i[1] = 1'b1;
        for (int k = 1; k <= 130; k++) begin
            step();
            if (k == 110) btn_i[1] = 1'b0;
            lvl = (k >= 10) && (k < 120);
            evt = (k == 10) || ((k >= 42) && (k < 120) && ((k - 42) % 16 == 0));
            exp = {lvl, 1'b0, k == 10, 1'b0, k == 120, 1'b0, evt, 1'b0};
            got = outs();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL repeat_hold k=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_release_mid_repeat();
        logic [7:0] got, exp;
        logic       evt;
        btn_i[1] = 1'b1;
        for (int k = 1; k <= 75; k++) begin
            step();
            if (k == 50) btn_i[1] = 1'b0;
            evt = (k == 10) || (k == 42) || (k == 58);
            exp = {(k >= 10) && (k < 60), 1'b0, k == 10, 1'b0, k == 60, 1'b0, evt, 1'b0};
            got = outs();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL release_mid k=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back_reset();
        logic [7:0] got, exp;
        logic       up;
        btn_i = 2'b11;
        for (int k = 1; k <= 20; k++) begin
            step();
            up = (k == 10);
            exp = {{2{k >= 10}}, {2{up}}, 2'b00, {2{up}}};
            got = outs();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL both_press k=%0d got=%b exp=%b", k, got, exp);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        got = outs();
        tests_run++;
        if (got !== 8'h00) begin
            tests_failed++;
            $display("FAIL async_reset got=%b exp=%b", got, 8'h00);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            up = (k == 11);
            exp = {{2{k >= 11}}, {2{up}}, 2'b00, {2{up}}};
            got = outs();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL post_reset_press k=%0d got=%b exp=%b", k, got, exp);
            end
        end
        btn_i = 2'b00;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp = {{2{k < 10}}, 2'b00, {2{k == 10}}, 2'b00};
            got = outs();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL post_reset_release k=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        btn_i        = 2'b00;
        test_reset();
        test_press();
        test_glitch();
        test_repeat_hold();
        test_release_mid_repeat();
        test_back_to_back_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
